load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage for the single-cycle RV32I core. It sits between the datapath's ALU result and store-data outputs and the data-memory bus. It converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned, byte-enabled bus transactions using a req/ack handshake, and stalls the core until each access completes. Load data comes back sign- or zero-extended, ready for the datapath's register write-back mux.

## Interface
- TIMEOUT, 255: maximum cycles to wait for `bus_ack`; 0 disables the timeout.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ls_req  in  1  core requests a memory access; held until `ls_stall` is low.
- ls_we  in  1  1 = store, 0 = load.
- ls_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- ls_addr  in  32  byte address (ALU result).
- ls_wdata  in  32  store data (rs2).
- ls_rdata  out  32  extended load result, registered; valid while `ls_stall`=0.
- ls_stall  out  1  combinational: `ls_req && state!=DONE`.
- ls_err  out  1  one-cycle pulse in DONE for an illegal, misaligned or timed-out access.
- bus_req  out  1  bus transaction request, registered.
- bus_we  out  1  bus write strobe.
- bus_addr  out  32  word address, bits [1:0] = 0.
- bus_be  out  4  byte-lane enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  single-cycle completion from memory.
- bus_rdata  in  32  read word; valid when `bus_ack`=1.

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE → BUS when `ls_req` is high and the request is legal. On this edge, latch `bus_addr`, `bus_we`, `bus_be`, `bus_wdata` and funct3/offset, and set `bus_req`=1.
- IDLE → DONE directly, with `ls_err`=1 and `ls_rdata`=0, when `ls_req` is high but the request is illegal. Illegal means funct3 is 011/110/111, or a store with funct3 other than 000/001/010. No bus transaction is issued.
- BUS → DONE on `bus_ack`. For loads, `ls_rdata` captures the extended data. `bus_req` drops on the same edge.
- BUS → DONE on timeout: when the wait counter reaches TIMEOUT, set `ls_err`=1 and `ls_rdata`=0, and drop `bus_req`.
- DONE → IDLE unconditionally after one cycle. DONE is the cycle in which the core writes back and advances the PC.
- Byte enables (off = `ls_addr[1:0]`):
  - B/BU: `be = 4'b0001<<off`.
  - H/HU: `be = 4'b0011<<(2*off[1])`.
  - W: `be = 4'b1111`.
- Store data: SB replicates `wdata[7:0]` ×4; SH replicates `wdata[15:0]` ×2; SW passes `wdata` through.
- Load extraction:
  - LB/LBU select byte `bus_rdata[8*off +: 8]`; LH/LHU select half `bus_rdata[16*off[1] +: 16]`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Store completion: `ls_rdata` is left unchanged.
- Bus outputs (`bus_addr`, `bus_we`, `bus_be`, `bus_wdata`) hold stable for the whole time `bus_req`=1.
- `bus_ack` outside BUS is ignored.
- `ls_req` dropping while in BUS: the bus transaction still completes normally; the result is discarded, and the FSM passes through DONE to IDLE.

## Timing
- Reset values: state=IDLE; `bus_req`, `bus_we`, `ls_err`=0; `bus_addr`, `bus_be`, `bus_wdata`, `ls_rdata`=0; wait counter=0. Reset acts immediately, even mid-transaction.
- Minimum latency: request seen in cycle 0, `bus_req` high in cycle 1, `bus_ack` in cycle 1, DONE in cycle 2. `ls_stall` is high in cycles 0–1 and low in cycle 2.
- Each additional wait cycle of `bus_ack` adds one stall cycle.
- Wait counter:
  - Cleared on entry to BUS; increments each BUS cycle without `bus_ack`. Width is clog2(TIMEOUT+1).
  - The timeout fires in the cycle where count == TIMEOUT, i.e. after TIMEOUT+1 BUS cycles.
  - `bus_ack` in the same cycle as the timeout wins: the access is treated as normal completion and `ls_err`=0.
- Back-to-back accesses: the earliest next transaction starts in the IDLE cycle after DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned access (H/HU/SH with `off[0]`=1, or W with `off`≠0) is illegal. It takes the IDLE → DONE path with `ls_err`=1, `ls_rdata`=0, and no bus transaction.
- Undefined: misalignment is not checked. Low address bits are silently masked (H uses `off[1]` only, W ignores `off`) and the access proceeds normally.

## Test plan
- Reset in BUS with `bus_req`=1 → `bus_req`=0 immediately; state IDLE; all outputs 0.
- SB of `ls_wdata`=0x000000A5 to 0x103, ack in 1 cycle → `bus_addr`=0x100, `be`=1000, `bus_wdata`=0xA5A5A5A5; `ls_stall` high 2 cycles then low 1.
- LB from 0x102 with `bus_rdata`=0x12F03456 → `ls_rdata`=0xFFFFFFF0. LBU from the same → 0x000000F0. LH from 0x102 → 0x000012F0.
- LW with `bus_ack` delayed 4 cycles → `bus_req`, `bus_addr` and `bus_be` stable throughout; `ls_rdata`=`bus_rdata`; 6 stall cycles.
- TIMEOUT=3 with no ack → DONE after 4 BUS cycles; `ls_err` pulses once; `ls_rdata`=0. Ack arriving on the 4th BUS cycle instead → no error.
- LW to 0x102: with `LSU_MISALIGN_TRAP_EN`, `ls_err`=1, no `bus_req`, 1 stall cycle; without it, `bus_addr`=0x100, `be`=1111, normal load. funct3=011 → `ls_err` in both builds.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack bus.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of masking the low address bits.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_stall,
    output logic        ls_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    // state  | meaning
    // IDLE   | waiting for ls_req
    // BUS    | bus_req high, waiting for bus_ack or timeout
    // DONE   | one-cycle write-back slot, stall released
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter is at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;

    logic          illegal;
    logic          timeout_hit;
    logic [3:0]    be_nxt;
    logic [31:0]   wdata_nxt;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_ext;

    assign ls_stall    = ls_req && (state != S_DONE);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_CNT);

    always_comb begin
        illegal = 1'b0;
        case (ls_funct3)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            default:                illegal = ls_we && ls_funct3[2];
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if (ls_funct3[1:0] == 2'b01 && ls_addr[0])
            illegal = 1'b1;
        if (ls_funct3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00)
            illegal = 1'b1;
`endif
    end

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = ls_wdata;
        case (ls_funct3[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << ls_addr[1:0];
                wdata_nxt = {4{ls_wdata[7:0]}};
            end
            2'b01: begin
                be_nxt    = ls_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{ls_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            ls_rdata  <= 32'd0;
            ls_err    <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            ls_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ls_req) begin
                        if (illegal) begin
                            state    <= S_DONE;
                            ls_err   <= 1'b1;
                            ls_rdata <= 32'd0;
                        end else begin
                            state     <= S_BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= ls_we;
                            bus_addr  <= {ls_addr[31:2], 2'b00};
                            bus_be    <= be_nxt;
                            bus_wdata <= wdata_nxt;
                            f3_q      <= ls_funct3;
                            off_q     <= ls_addr[1:0];
                            wait_cnt  <= '0;
                        end
                    end
                end
                S_BUS: begin
                    // An ack landing on the timeout cycle counts as a normal completion.
                    if (bus_ack) begin
                        state   <= S_DONE;
                        bus_req <= 1'b0;
                        if (!bus_we && ls_req)
                            ls_rdata <= load_ext;
                    end else if (timeout_hit) begin
                        state    <= S_DONE;
                        bus_req  <= 1'b0;
                        ls_err   <= 1'b1;
                        ls_rdata <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset/abort sequences, random accesses vs. a reference model.
module tb_load_store_unit;
    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        ls_req, ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_stall, ls_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_stall(ls_stall), .ls_err(ls_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    logic [31:0] model_rd = 32'd0;

    logic        obs_done, obs_saw_bus, obs_stable, obs_err, obs_err_after, obs_req_done, obs_we;
    logic [31:0] obs_addr, obs_wd, obs_rd;
    logic [3:0]  obs_be;
    int          obs_stalls;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        legal;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic        chk_rd;
        logic        e_err;
        int          e_stalls;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, int delay, logic legal, logic [31:0] e_addr,
                                logic [3:0] e_be, logic [31:0] e_wd, logic [31:0] e_rd,
                                logic chk_rd, logic e_err, int e_stalls);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.delay = delay;
        v.legal = legal; v.e_addr = e_addr; v.e_be = e_be; v.e_wd = e_wd; v.e_rd = e_rd;
        v.chk_rd = chk_rd; v.e_err = e_err; v.e_stalls = e_stalls;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: sizes, lanes and extension computed arithmetically from the RV32I rules.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                                  input logic [31:0] prev,
                                  output logic legal, output logic [31:0] e_addr, output logic [3:0] e_be,
                                  output logic [31:0] e_wd, output logic [31:0] e_rd,
                                  output logic e_err, output int e_stalls);
        int off, size, lane;
        logic [31:0] v, mask;
        off  = int'(addr % 4);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && !(we && f3 >= 3'd4);
`ifdef LSU_MISALIGN_TRAP_EN
        if (off % size != 0) legal = 1'b0;
`endif
        lane   = (size == 1) ? off : (size == 2) ? (off / 2) * 2 : 0;
        e_addr = addr - 32'(off);
        e_be   = 4'(((1 << size) - 1) << lane);
        mask   = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
        e_wd   = (size == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
                 (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
        v = (rdata >> (8 * lane)) & mask;
        if (f3 < 3'd4 && size < 4 && v[8 * size - 1]) v = v - 32'(1 << (8 * size));
        e_err = 1'b0;
        e_rd  = prev;
        if (!legal) begin
            e_err = 1'b1; e_rd = 32'd0; e_stalls = 1;
        end else if (delay <= TO) begin
            e_stalls = delay + 2;
            if (!we) e_rd = v;
        end else begin
            e_err = 1'b1; e_rd = 32'd0; e_stalls = TO + 2;
        end
    endfunction

    // Drives one access; bus_ack comes in BUS cycle number 'delay' (0 = first BUS cycle).
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
        int bc;
        @(posedge clk); #1;
        ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
        obs_done = 1'b0; obs_saw_bus = 1'b0; obs_stable = 1'b1; obs_stalls = 0;
        obs_err = 1'b0; obs_rd = 32'd0; obs_req_done = 1'b0;
        bc = 0;
        for (int c = 0; c < 200 && !obs_done; c++) begin
            @(negedge clk);
            if (ls_stall) begin
                obs_stalls++;
                if (bus_req) begin
                    if (!obs_saw_bus) begin
                        obs_saw_bus = 1'b1;
                        obs_addr = bus_addr; obs_be = bus_be; obs_wd = bus_wdata; obs_we = bus_we;
                    end else if (bus_addr !== obs_addr || bus_be !== obs_be ||
                                 bus_wdata !== obs_wd || bus_we !== obs_we) begin
                        obs_stable = 1'b0;
                    end
                    bus_ack   = (bc == delay);
                    bus_rdata = (bc == delay) ? rdata : $urandom;
                    bc++;
                end else if (obs_saw_bus) begin
                    obs_stable = 1'b0;
                end
            end else begin
                obs_done = 1'b1;
                obs_err = ls_err; obs_rd = ls_rdata; obs_req_done = bus_req;
                ls_req = 1'b0;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        @(negedge clk);
        obs_err_after = ls_err;
    endtask

    task automatic compare_all(input string name, input logic we, input logic legal,
                               input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd,
                               input logic [31:0] e_rd, input logic chk_rd, input logic e_err, input int e_stalls);
        chk({name, ".done"}, 32'(obs_done), 32'd1);
        chk({name, ".stalls"}, 32'(obs_stalls), 32'(e_stalls));
        chk({name, ".err"}, 32'(obs_err), 32'(e_err));
        chk({name, ".err_pulse"}, 32'(obs_err_after), 32'd0);
        chk({name, ".req_in_done"}, 32'(obs_req_done), 32'd0);
        chk({name, ".bus_issued"}, 32'(obs_saw_bus), 32'(legal));
        if (chk_rd) chk({name, ".rdata"}, obs_rd, e_rd);
        if (legal && obs_saw_bus) begin
            chk({name, ".addr"}, obs_addr, e_addr);
            chk({name, ".be"}, 32'(obs_be), 32'(e_be));
            chk({name, ".we"}, 32'(obs_we), 32'(we));
            chk({name, ".stable"}, 32'(obs_stable), 32'd1);
            if (we) chk({name, ".wdata"}, obs_wd, e_wd);
        end
    endtask

    initial begin
        logic        legal, e_err;
        logic [31:0] e_addr, e_wd, e_rd, a, w, r;
        logic [3:0]  e_be;
        logic [2:0]  f3;
        logic        we;
        int          e_st, d;

        reset = 1'b1; ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = 3'd0; ls_addr = 32'd0;
        ls_wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        #12;
        chk("rst.bus_req", 32'(bus_req), 32'd0);
        chk("rst.ls_err", 32'(ls_err), 32'd0);
        chk("rst.ls_rdata", ls_rdata, 32'd0);
        chk("rst.bus_addr", bus_addr, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Load something so the mid-transaction reset has a non-zero ls_rdata to clear.
        run_access(1'b0, 3'b010, 32'h200, 32'd0, 32'h1357_2468, 1);
        model(1'b0, 3'b010, 32'h200, 32'd0, 32'h1357_2468, 1, model_rd, legal, e_addr, e_be, e_wd, e_rd, e_err, e_st);
        compare_all("prime", 1'b0, legal, e_addr, e_be, e_wd, e_rd, 1'b1, e_err, e_st);
        model_rd = e_rd;

        @(posedge clk); #1;
        ls_we = 1'b1; ls_funct3 = 3'b010; ls_addr = 32'h304; ls_wdata = 32'h5555_AAAA; ls_req = 1'b1;
        @(posedge clk); #1;
        chk("midrst.bus_req_before", 32'(bus_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst.bus_req", 32'(bus_req), 32'd0);
        chk("midrst.bus_we", 32'(bus_we), 32'd0);
        chk("midrst.bus_addr", bus_addr, 32'd0);
        chk("midrst.bus_be", 32'(bus_be), 32'd0);
        chk("midrst.bus_wdata", bus_wdata, 32'd0);
        chk("midrst.ls_rdata", ls_rdata, 32'd0);
        chk("midrst.ls_stall_idle", 32'(ls_stall), 32'd1);
        ls_req = 1'b0;
        @(negedge clk); reset = 1'b0;
        model_rd = 32'd0;

        vecs.push_back(mk(1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 1, 32'h100, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0, 0, 2));
        vecs.push_back(mk(0, 3'b000, 32'h102, 32'h0, 32'h12F0_3456, 0, 1, 32'h100, 4'b0100, 32'h0, 32'hFFFF_FFF0, 1, 0, 2));
        vecs.push_back(mk(0, 3'b100, 32'h102, 32'h0, 32'h12F0_3456, 0, 1, 32'h100, 4'b0100, 32'h0, 32'h0000_00F0, 1, 0, 2));
        vecs.push_back(mk(0, 3'b001, 32'h102, 32'h0, 32'h12F0_3456, 0, 1, 32'h100, 4'b1100, 32'h0, 32'h0000_12F0, 1, 0, 2));
        vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 4, 1, 32'h100, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1, 0, 6));
        vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 32'h1111_1111, 99, 1, 32'h100, 4'b1111, 32'h0, 32'h0, 1, 1, TO + 2));
        vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 32'h0BAD_F00D, TO, 1, 32'h100, 4'b1111, 32'h0, 32'h0BAD_F00D, 1, 0, TO + 2));
        vecs.push_back(mk(0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 1, 1));
        vecs.push_back(mk(0, 3'b010, 32'h108, 32'h0, 32'h7777_0001, 0, 1, 32'h108, 4'b1111, 32'h0, 32'h7777_0001, 1, 0, 2));
        vecs.push_back(mk(1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 1, 1));
        vecs.push_back(mk(1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 0, 1, 32'h100, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 0, 2));
        vecs.push_back(mk(0, 3'b001, 32'h100, 32'h0, 32'h0000_8001, 1, 1, 32'h100, 4'b0011, 32'h0, 32'hFFFF_8001, 1, 0, 3));
        vecs.push_back(mk(0, 3'b101, 32'h100, 32'h0, 32'h0000_8001, 0, 1, 32'h100, 4'b0011, 32'h0, 32'h0000_8001, 1, 0, 2));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, 3'b010, 32'h102, 32'h0, 32'hCAFE_BABE, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 1, 1));
`else
        vecs.push_back(mk(0, 3'b010, 32'h102, 32'h0, 32'hCAFE_BABE, 0, 1, 32'h100, 4'b1111, 32'h0, 32'hCAFE_BABE, 1, 0, 2));
`endif
        vecs.push_back(mk(0, 3'b000, 32'h101, 32'h0, 32'h0000_7F00, 0, 1, 32'h100, 4'b0010, 32'h0, 32'h0000_007F, 1, 0, 2));
        vecs.push_back(mk(1, 3'b010, 32'h20C, 32'hC001_D00D, 32'h0, 2, 1, 32'h20C, 4'b1111, 32'hC001_D00D, 32'h0, 0, 0, 4));
        vecs.push_back(mk(1, 3'b111, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            run_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].delay);
            compare_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].legal, vecs[i].e_addr, vecs[i].e_be,
                        vecs[i].e_wd, vecs[i].e_rd, vecs[i].chk_rd, vecs[i].e_err, vecs[i].e_stalls);
            if (vecs[i].chk_rd) model_rd = vecs[i].e_rd;
        end

        // Core abandons the load mid-BUS: the bus cycle finishes but ls_rdata keeps its old value.
        @(posedge clk); #1;
        ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h400; ls_req = 1'b1;
        @(posedge clk); #1;
        chk("drop.bus_req", 32'(bus_req), 32'd1);
        ls_req = 1'b0;
        @(negedge clk);
        chk("drop.stall", 32'(ls_stall), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
        @(posedge clk); #1; bus_ack = 1'b0;
        chk("drop.bus_req_done", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        chk("drop.rdata", ls_rdata, model_rd);

        // A stray ack while idle must not start or complete anything.
        @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h4242_4242;
        @(posedge clk); #1; bus_ack = 1'b0;
        chk("stray_ack.bus_req", 32'(bus_req), 32'd0);
        chk("stray_ack.rdata", ls_rdata, model_rd);
        chk("stray_ack.err", 32'(ls_err), 32'd0);

        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            w  = $urandom;
            r  = $urandom;
            d  = $urandom_range(0, 9);
            if (d > TO) d = 99;
            run_access(we, f3, a, w, r, d);
            model(we, f3, a, w, r, d, model_rd, legal, e_addr, e_be, e_wd, e_rd, e_err, e_st);
            compare_all($sformatf("rnd%0d", i), we, legal, e_addr, e_be, e_wd, e_rd, 1'b1, e_err, e_st);
            model_rd = e_rd;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
